// File: rtl/clken_sched.sv
// Clock-enable scheduler for the VIC-20 core.
// Produces single-cycle CPU, VIA and VIA x4 enable pulses from the system
// clock. Each frame is DIV clocks long and equals one 1 MHz CPU period.
// The rate and the pause/step mode are latched only at frame boundaries, so
// no pulse is ever shortened or duplicated when the speed or mode changes.
module clken_sched #(
   parameter int unsigned DIV      = 25,
   parameter int unsigned ACTIVE   = 16,
   parameter int unsigned RATE_W   = 2,
   parameter int unsigned VIA4_MUL = 4,
   parameter int unsigned CYC_W    = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [RATE_W-1:0] rate,
   input  logic              pause_req,
   input  logic              step,
   output logic              cpu_clken,
   output logic              cpu_clken_d1,
   output logic              via_clken,
   output logic              via4_clken,
   output logic              pause_ack,
   output logic [CYC_W-1:0]  cyc_count
);

   localparam int unsigned CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned MUL_SH = (VIA4_MUL > 1) ? $clog2(VIA4_MUL) : 0;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

   // Per-frame operating mode, fixed for the whole frame.
   typedef enum logic [1:0] {
      ModeRun,
      ModePause,
      ModeStep
   } mode_e;

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [RATE_W-1:0] rate_q, rate_d;
   mode_e             mode_q, mode_d;
   logic              paused_q, paused_d;
   logic              step_pend_q, step_pend_d;
   logic              cpu_q, cpu_d;
   logic              via4_q, via4_d;
   logic              cpu_d1_q;
   logic [CYC_W-1:0]  cyc_q, cyc_d;

   logic              wrap;
   int unsigned       p_len;
   int unsigned       q_len;
   logic [CNT_W-1:0]  p_mask;
   logic [CNT_W-1:0]  q_mask;
   logic              in_active;
   logic              in_step_win;

   assign wrap        = (cnt_q == CNT_LAST);
   assign in_active   = (32'(cnt_q) < ACTIVE);
   assign in_step_win = (32'(cnt_q) < p_len);

   // CPU and VIA x4 periods for the latched rate; both are powers of two,
   // so "cnt mod period == 0" reduces to masking the low counter bits.
   always_comb begin
      p_len = ACTIVE >> rate_q;
      if (p_len == 0) begin
         p_len = 1;
      end
      q_len = p_len >> MUL_SH;
      if (q_len == 0) begin
         q_len = 1;
      end
      p_mask = CNT_W'(p_len - 1);
      q_mask = CNT_W'(q_len - 1);
   end

   // Enable conditions for the current slot; registered into the outputs.
   always_comb begin
      cpu_d  = 1'b0;
      via4_d = 1'b0;
      case (mode_q)
         ModeRun: begin
            cpu_d  = in_active && ((cnt_q & p_mask) == '0);
            via4_d = in_active && ((cnt_q & q_mask) == '0);
         end
         ModeStep: begin
            // One CPU cycle, plus the VIA x4 ticks belonging to that cycle.
            cpu_d  = (cnt_q == '0);
            via4_d = in_step_win && ((cnt_q & q_mask) == '0);
         end
         default: begin
            cpu_d  = 1'b0;
            via4_d = 1'b0;
         end
      endcase
   end

   // Slot counter, frame-boundary mode latch and step request tracking.
   always_comb begin
      cnt_d       = wrap ? '0 : cnt_q + CNT_W'(1);
      rate_d      = rate_q;
      mode_d      = mode_q;
      paused_d    = paused_q;
      step_pend_d = step_pend_q;

      if (wrap) begin
         rate_d = rate;
         if (!pause_req) begin
            mode_d      = ModeRun;
            paused_d    = 1'b0;
            step_pend_d = 1'b0;
         end else if (step_pend_q) begin
            mode_d      = ModeStep;
            paused_d    = 1'b1;
            step_pend_d = 1'b0;
         end else begin
            mode_d   = ModePause;
            paused_d = 1'b1;
         end
      end

      // A step arriving on the boundary edge itself is kept for the next
      // boundary; steps are meaningless once the next frame is RUN.
      if (step && paused_q && !(wrap && !pause_req)) begin
         step_pend_d = 1'b1;
      end
   end

   // Cycle counter advances once per delivered CPU enable pulse.
   always_comb begin
      cyc_d = cyc_q;
      if (cpu_q) begin
         cyc_d = cyc_q + CYC_W'(1);
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q       <= '0;
         rate_q      <= '0;
         mode_q      <= ModeRun;
         paused_q    <= 1'b0;
         step_pend_q <= 1'b0;
         cpu_q       <= 1'b0;
         via4_q      <= 1'b0;
         cpu_d1_q    <= 1'b0;
         cyc_q       <= '0;
      end else begin
         cnt_q       <= cnt_d;
         rate_q      <= rate_d;
         mode_q      <= mode_d;
         paused_q    <= paused_d;
         step_pend_q <= step_pend_d;
         cpu_q       <= cpu_d;
         via4_q      <= via4_d;
         cpu_d1_q    <= cpu_q;
         cyc_q       <= cyc_d;
      end
   end

   assign cpu_clken    = cpu_q;
   assign via_clken    = cpu_q;
   assign via4_clken   = via4_q;
   assign cpu_clken_d1 = cpu_d1_q;
   assign pause_ack    = paused_q;
   assign cyc_count    = cyc_q;

endmodule

// File: tb/tb_clken_sched.sv
// Scoreboard bench for clken_sched: the stimulus thread pushes the expected
// pulse times per frame, a negedge monitor pops and compares on every pulse.
module tb_clken_sched;

   localparam int DIV = 25;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  rate = 2'd0;
   logic        pause_req = 1'b0;
   logic        step = 1'b0;
   logic        cpu_clken;
   logic        cpu_clken_d1;
   logic        via_clken;
   logic        via4_clken;
   logic        pause_ack;
   logic [31:0] cyc_count;

   int tick = 0;
   int t0 = 0;
   int pulses = 0;
   bit mon_en = 1'b0;
   logic ack_prev = 1'b0;
   int n_pass = 0;
   int n_total = 0;

   int cpu_q[$];
   int via_q[$];
   int d1_q[$];
   int v4_q[$];
   int cyc_exp_q[$];
   int ack_t_q[$];
   int ack_v_q[$];

   clken_sched dut (
      .clk          (clk),
      .reset        (reset),
      .rate         (rate),
      .pause_req    (pause_req),
      .step         (step),
      .cpu_clken    (cpu_clken),
      .cpu_clken_d1 (cpu_clken_d1),
      .via_clken    (via_clken),
      .via4_clken   (via4_clken),
      .pause_ack    (pause_ack),
      .cyc_count    (cyc_count)
   );

   always #20 clk = ~clk;

   always @(posedge clk) tick <= tick + 1;

   task automatic check(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (tick %0d)", name, act, exp, tick);
   endtask

   task automatic unexpected(input string name);
      n_total++;
      $display("FAIL %s: got pulse at tick %0d expected none", name, tick);
   endtask

   // Negedge index at which the slot counter shows slot s of frame f.
   function automatic int at(input int f, input int s);
      return t0 + DIV * f + s - 1;
   endfunction

   // Expected pulses of one frame: cpu_n CPU pulses cpu_stride apart and
   // v4_n VIA x4 pulses v4_stride apart, both starting at slot 0.
   task automatic push_frame(input int f, input int cpu_stride, input int cpu_n,
                             input int v4_stride, input int v4_n);
      for (int i = 0; i < cpu_n; i++) begin
         int t;
         t = t0 + DIV * f + i * cpu_stride;
         cpu_q.push_back(t);
         via_q.push_back(t);
         d1_q.push_back(t + 1);
         cyc_exp_q.push_back(pulses);
         pulses++;
      end
      for (int i = 0; i < v4_n; i++) v4_q.push_back(t0 + DIV * f + i * v4_stride);
   endtask

   task automatic push_ack(input int t, input int v);
      ack_t_q.push_back(t);
      ack_v_q.push_back(v);
   endtask

   task automatic wait_tick(input int t);
      if (tick > t) begin
         $display("FAIL wait_tick: at tick %0d already past %0d", tick, t);
         $fatal(1);
      end
      while (tick < t) @(negedge clk);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_cpu_clken"}, cpu_clken, 0);
      check({tag, "_cpu_clken_d1"}, cpu_clken_d1, 0);
      check({tag, "_via_clken"}, via_clken, 0);
      check({tag, "_via4_clken"}, via4_clken, 0);
      check({tag, "_pause_ack"}, pause_ack, 0);
      check({tag, "_cyc_count"}, cyc_count, 0);
   endtask

   // Monitor: every pulse or pause_ack edge must match the queue head.
   always @(negedge clk) begin
      if (mon_en) begin
         if (cpu_clken) begin
            if (cpu_q.size() == 0) unexpected("cpu_clken");
            else begin
               check("cpu_clken_tick", tick, cpu_q.pop_front());
               check("cyc_count_at_pulse", cyc_count, cyc_exp_q.pop_front());
            end
         end
         if (via_clken) begin
            if (via_q.size() == 0) unexpected("via_clken");
            else check("via_clken_tick", tick, via_q.pop_front());
         end
         if (cpu_clken_d1) begin
            if (d1_q.size() == 0) unexpected("cpu_clken_d1");
            else check("cpu_clken_d1_tick", tick, d1_q.pop_front());
         end
         if (via4_clken) begin
            if (v4_q.size() == 0) unexpected("via4_clken");
            else check("via4_clken_tick", tick, v4_q.pop_front());
         end
         if (pause_ack !== ack_prev) begin
            if (ack_t_q.size() == 0) unexpected("pause_ack");
            else begin
               check("pause_ack_tick", tick, ack_t_q.pop_front());
               check("pause_ack_val", pause_ack, ack_v_q.pop_front());
            end
            ack_prev = pause_ack;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int r;
      repeat (3) @(negedge clk);
      check_idle("reset");
      reset = 1'b0;
      t0 = tick + 1;
      mon_en = 1'b1;

      // Rate 0: 1 CPU pulse, VIA x4 at slots 0,4,8,12.
      push_frame(0, 16, 1, 4, 4);
      push_frame(1, 16, 1, 4, 4);
      push_frame(2, 16, 1, 4, 4);
      push_frame(3, 16, 1, 4, 4);
      wait_tick(at(3, 5));
      rate = 2'd2;
      push_frame(4, 4, 4, 1, 16);
      push_frame(5, 4, 4, 1, 16);
      wait_tick(t0 + 99);
      check("cyc_after_100", cyc_count, 4);

      wait_tick(at(5, 5));
      rate = 2'd0;
      push_frame(6, 16, 1, 4, 4);
      // Mid-frame switch to rate 3 applies from the next frame only.
      wait_tick(at(6, 10));
      rate = 2'd3;
      push_frame(7, 2, 8, 1, 16);
      push_frame(8, 2, 8, 1, 16);
      wait_tick(at(8, 5));
      rate = 2'd0;
      push_frame(9, 16, 1, 4, 4);

      // Pause mid-frame; a step while still running must be ignored.
      wait_tick(at(9, 10));
      pause_req = 1'b1;
      push_ack(at(10, 0), 1);
      wait_tick(at(9, 15));
      step = 1'b1;
      wait_tick(at(9, 16));
      step = 1'b0;
      wait_tick(at(10, 2));
      check("cyc_frozen_a", cyc_count, 30);

      // Two steps in one paused frame give exactly one STEP frame.
      wait_tick(at(11, 5));
      step = 1'b1;
      wait_tick(at(11, 6));
      step = 1'b0;
      wait_tick(at(11, 12));
      step = 1'b1;
      wait_tick(at(11, 13));
      step = 1'b0;
      push_frame(12, 16, 1, 4, 4);
      wait_tick(at(11, 20));
      check("cyc_frozen_b", cyc_count, 30);
      wait_tick(at(13, 10));
      check("cyc_after_step", cyc_count, 31);
      check("ack_after_step", pause_ack, 1);

      // Reset while paused with pause_req held: one RUN frame, then PAUSE.
      wait_tick(at(13, 12));
      r = tick;
      reset = 1'b1;
      push_ack(r + 1, 0);
      wait_tick(r + 3);
      check_idle("reset2");
      reset = 1'b0;
      t0 = tick + 1;
      pulses = 0;
      push_frame(0, 16, 1, 4, 4);
      push_ack(at(1, 0), 1);
      wait_tick(t0 + 60);
      check("cyc_after_reset2", cyc_count, 1);
      check("cpu_q_empty", cpu_q.size(), 0);
      check("via_q_empty", via_q.size(), 0);
      check("d1_q_empty", d1_q.size(), 0);
      check("v4_q_empty", v4_q.size(), 0);
      check("ack_q_empty", ack_t_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
